// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: MD_ctr op codes, sequencer states and
// default latencies, used by the control unit and the md datapath.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  // mthi/mtlo share the 10x prefix.
  function automatic logic is_move_op(input logic [2:0] op);
    return op[2:1] == 2'b10;
  endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath: one shared 64-bit multiplier and
// one shared unsigned divider, with sign fix-up for the signed forms.
module md_alu
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result
);

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic        signed_div;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q;
  logic [31:0] r;

  always_comb begin
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    ext_a   = op[0] ? {32'd0, a} : {{32{a[31]}}, a};
    ext_b   = op[0] ? {32'd0, b} : {{32{b[31]}}, b};
    product = ext_a * ext_b;

    signed_div = (op == MD_DIV);
    neg_q      = signed_div & (a[31] ^ b[31]);
    neg_r      = signed_div & a[31];
    mag_a      = (signed_div & a[31]) ? -a : a;
    mag_b      = (signed_div & b[31]) ? -b : b;
    divisor    = (mag_b == '0) ? 32'd1 : mag_b;
    uq         = mag_a / divisor;
    ur         = mag_a % divisor;
    q          = neg_q ? -uq : uq;
    r          = neg_r ? -ur : ur;

    case (op)
      MD_MULT,
      MD_MULTU: result = product;
      MD_DIV,
      MD_DIVU:  result = {r, q};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: issue FSM, latency counter, HI/LO registers and
// the stall request to the hazard unit. Arithmetic lives in md_alu.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Enmultdiv,
  input  logic [2:0]  MD_ctr,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush_E,
  input  logic        use_md_D,
  output logic        Busy,
  output logic        stall_md,
  output logic [31:0] HIO,
  output logic [31:0] LOO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        idle;
  logic        issue;
  logic        accept;
  logic        move_hilo;
  logic [63:0] alu_result;

  md_alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    idle      = (state_q == ST_IDLE);
    issue     = Start & Enmultdiv & ~flush_E;
    accept    = issue & idle;
    move_hilo = Enmultdiv & ~Start & ~flush_E & idle & is_move_op(MD_ctr);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = MD_ctr;
          a_d  = A;
          b_d  = B;
          if (MD_ctr[1]) begin
            state_d = ST_DIV;
            cnt_d   = DIV_LOAD;
          end else begin
            state_d = ST_MUL;
            cnt_d   = MUL_LOAD;
          end
        end else if (move_hilo) begin
          if (MD_ctr == MD_MTHI) hi_d = A;
          else                   lo_d = A;
        end
      end
      ST_MUL,
      ST_DIV: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          // Division by zero still runs the full latency but commits nothing.
          if (state_q == ST_MUL || b_q != '0) begin
            hi_d = alu_result[63:32];
            lo_d = alu_result[31:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy     = (state_q != ST_IDLE);
  assign stall_md = reset & use_md_D & (Busy | issue);
  assign HIO      = hi_q;
  assign LOO      = lo_q;

  no_issue_while_busy: assert property (
    @(posedge clk) disable iff (!reset)
      !(Busy && Enmultdiv && (Start || is_move_op(MD_ctr)))
  );

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- Start  in  1  E-stage mult/multu/div/divu issue strobe.
- Enmultdiv  in  1  E-stage instruction targets the md unit (Start or mthi/mtlo).
- MD_ctr  in  3  op code: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
- A  in  32  rs operand (E stage, forwarded).
- B  in  32  rt operand (E stage, forwarded).
- flush_E  in  1  exception/interrupt kills the E-stage instruction this cycle.
- use_md_D  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- Busy  out  1  operation in progress.
- stall_md  out  1  stall request to the hazard unit.
- HIO  out  32  HI register.
- LOO  out  32  LO register.

Function
REQ-003 FSM states SHALL be IDLE, MUL, DIV; reset state IDLE.
REQ-004 Accept condition = Start & Enmultdiv & ~flush_E & state==IDLE.
REQ-005 On accept, operands SHALL be latched, and the state SHALL move to MUL (MD_ctr 00x) or DIV (01x) with cnt = N-1, where N = MULT_CYCLES or DIV_CYCLES.
REQ-006 Busy SHALL be 1 exactly when state != IDLE; it covers N consecutive cycles starting the cycle after accept.
REQ-007 In MUL/DIV, cnt SHALL decrement each cycle; at cnt==0 the FSM SHALL return to IDLE and write HI/LO on the same edge, so new values are visible the first cycle Busy is 0.
REQ-008 mult: {HI,LO} = signed A*B (64-bit). multu: {HI,LO} = unsigned A*B (64-bit).
REQ-009 div: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend. divu: unsigned quotient and remainder.
REQ-010 div/divu with B==0 SHALL take the full DIV_CYCLES and leave HI/LO unchanged.
REQ-011 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-012 mthi/mtlo (Enmultdiv & ~Start & MD_ctr 10x & ~flush_E & IDLE) SHALL write A to HI/LO on that edge in a single cycle, with no Busy.
REQ-013 Start, mthi or mtlo while Busy SHALL be ignored; the hazard unit guarantees this never happens, and an assertion SHALL check it.
REQ-014 flush_E in the accept cycle SHALL cancel the operation: no state change, HI/LO untouched.
REQ-015 flush_E while Busy SHALL NOT abort; the in-flight operation completes and commits.
REQ-016 stall_md SHALL equal use_md_D & (Busy | (Start & Enmultdiv & ~flush_E)), and SHALL be combinational.

Reset
REQ-017 reset==0 at a clock edge SHALL force state=IDLE, cnt=0, HI=0, LO=0, latched operands=0, and Busy=0, including mid-operation.
REQ-018 A pending result SHALL be discarded on reset, and stall_md SHALL be 0 during reset.

Structure
REQ-019 The MD_ctr encodings, FSM state encoding and default latency constants SHALL live in the shared package md_pkg, used by the control unit and by this block.
REQ-020 Arithmetic SHALL sit in one combinational sub-module, md_alu (operands + MD_ctr -> 64-bit result), computed from the latched operands.
REQ-021 md_sequencer SHALL own only the FSM, counter, HI/LO and stall logic.

Verification
REQ-022 mult: A=0xFFFFFFFE, B=3, Start at cycle t -> Busy high t+1..t+5; HI=0xFFFFFFFF, LO=0xFFFFFFFA at t+6.
REQ-023 divu: A=100, B=7 -> Busy for 10 cycles; then LO=14, HI=2. div: A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-024 div with B=0 after mthi A=0x1234 and mtlo A=0x5678 -> Busy 10 cycles; HI=0x1234, LO=0x5678 unchanged.
REQ-025 Flush cases:
- Start with flush_E=1 -> Busy stays 0, HI/LO unchanged.
- flush_E pulse at busy cycle 3 -> result still commits.
REQ-026 Stall: mult issued, then mflo held in D (use_md_D=1) -> stall_md=1 in the issue cycle and all 5 busy cycles, 0 the cycle HI/LO update.
REQ-027 Reset: reset=0 at busy cycle 4 of div -> next cycle Busy=0, HI=LO=0; a new mult then completes normally.
